// File: rtl/aurora_link_seq_if.sv
// Control/status bundle between the Aurora bring-up sequencer (master) and the
// Aurora core / traffic logic side (slave).
interface aurora_link_seq_if;
  logic       enable;
  logic [2:0] loopback_cfg;
  logic       channel_up;
  logic       PMA_INIT;
  logic       RESET;
  logic [2:0] loopback;
  logic       start;
  logic       link_ok;
  logic       fail;
  logic [3:0] retry_cnt;

  modport master (
    input  enable, loopback_cfg, channel_up,
    output PMA_INIT, RESET, loopback, start, link_ok, fail, retry_cnt
  );

  modport slave (
    output enable, loopback_cfg, channel_up,
    input  PMA_INIT, RESET, loopback, start, link_ok, fail, retry_cnt
  );
endinterface

// File: rtl/aurora_link_seq.sv
// Aurora link reset/bring-up sequencer: PMA_INIT/RESET ordering, loopback latch,
// channel_up wait with timeout/retry. Optional macro AURORA_SEQ_DEBOUNCE_EN adds
// a 16-sample channel_up qualifier.
module aurora_link_seq #(
  parameter int unsigned PMA_INIT_CYCLES   = 128,
  parameter int unsigned RESET_HOLD_CYCLES = 64,
  parameter int unsigned UP_TIMEOUT        = 1048576,
  parameter int unsigned MAX_RETRIES       = 4
) (
  input  logic              INIT_CLK,
  input  logic              RESET_N,
  aurora_link_seq_if.master bus
);

  localparam int unsigned CntMax     = 32'h00FF_FFFF;
  localparam logic [23:0] PmaLast    = 24'(PMA_INIT_CYCLES - 1);
  localparam logic [23:0] HoldLast   = 24'(RESET_HOLD_CYCLES - 1);
  // A 24-bit counter cannot hold 2^24; clamp so the largest timeout still fires.
  localparam logic [23:0] TimeoutCnt = 24'((UP_TIMEOUT > CntMax) ? CntMax : UP_TIMEOUT);
  localparam logic [3:0]  MaxRetry   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle,
    StAssert,
    StPmaRel,
    StWaitUp,
    StLinkUp,
    StFail
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [3:0]  retry_inc;
  logic [2:0]  lb_q, lb_d;
  logic        pma_q, pma_d;
  logic        rst_q, rst_d;
  logic        start_q, start_d;
  logic        link_q, link_d;
  logic        fail_q, fail_d;
  logic        lb_change;
  logic        up_qual;

`ifdef AURORA_SEQ_DEBOUNCE_EN
  logic [3:0] run_q, run_d;

  // run_q counts earlier consecutive high samples; the 16th high sample qualifies.
  assign up_qual = bus.channel_up && (run_q == 4'd15);

  always_comb begin
    run_d = '0;
    if (state_q == StWaitUp && state_d == StWaitUp && bus.channel_up) begin
      run_d = (run_q == 4'd15) ? run_q : run_q + 4'd1;
    end
  end

  always_ff @(posedge INIT_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`else
  assign up_qual = bus.channel_up;
`endif

  assign lb_change = (bus.loopback_cfg != lb_q);
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lb_d    = lb_q;
    cnt_d   = cnt_q + 24'd1;

    if (!bus.enable) begin
      state_d = StIdle;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StAssert;
        StAssert: begin
          if (cnt_q == PmaLast) state_d = StPmaRel;
        end
        StPmaRel: begin
          if (cnt_q == HoldLast) state_d = StWaitUp;
        end
        StWaitUp: begin
          if (lb_change) begin
            state_d = StAssert;
          end else if (up_qual) begin
            state_d = StLinkUp;
          end else if (cnt_q == TimeoutCnt) begin
            retry_d = retry_inc;
            state_d = (retry_inc == MaxRetry) ? StFail : StAssert;
          end
        end
        StLinkUp: begin
          if (lb_change) begin
            state_d = StAssert;
          end else if (!bus.channel_up) begin
            retry_d = '0;
            state_d = StAssert;
          end
        end
        StFail: state_d = StFail;
        default: state_d = StIdle;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == StAssert && state_q != StAssert) lb_d = bus.loopback_cfg;

    // Outputs are decoded from the next state so they change on the transition edge.
    pma_d   = (state_d == StIdle) || (state_d == StAssert) || (state_d == StFail);
    rst_d   = pma_d || (state_d == StPmaRel);
    start_d = (state_d == StLinkUp);
    link_d  = (state_d == StLinkUp);
    fail_d  = (state_d == StFail);
  end

  always_ff @(posedge INIT_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      retry_q <= '0;
      lb_q    <= '0;
      pma_q   <= 1'b1;
      rst_q   <= 1'b1;
      start_q <= 1'b0;
      link_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lb_q    <= lb_d;
      pma_q   <= pma_d;
      rst_q   <= rst_d;
      start_q <= start_d;
      link_q  <= link_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.PMA_INIT  = pma_q;
  assign bus.RESET     = rst_q;
  assign bus.loopback  = lb_q;
  assign bus.start     = start_q;
  assign bus.link_ok   = link_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_aurora_link_seq.sv
// Randomized bench for aurora_link_seq: a time-since-attempt reference model
// feeds an expected-output queue that a negedge monitor drains and compares.
module tb_aurora_link_seq;
  localparam int P    = 8;
  localparam int R    = 4;
  localparam int T    = 100;
  localparam int MAXR = 2;
  localparam int NCYC = 30000;

  localparam int MIdle    = 0;
  localparam int MAttempt = 1;
  localparam int MUp      = 2;
  localparam int MFail    = 3;

  typedef struct packed {
    logic       pma;
    logic       rst;
    logic [2:0] lb;
    logic       start;
    logic       link_ok;
    logic       fail;
    logic [3:0] retry;
  } out_t;

  logic clk;
  logic rst_n_drv;
  aurora_link_seq_if bus ();

  aurora_link_seq #(
    .PMA_INIT_CYCLES  (P),
    .RESET_HOLD_CYCLES(R),
    .UP_TIMEOUT       (T),
    .MAX_RETRIES      (MAXR)
  ) dut (
    .INIT_CLK(clk),
    .RESET_N (rst_n_drv),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 0;
  out_t exp_q[$];

  // Reference model: attempt elapsed time m_t drives the PMA/RESET phases.
  int         m_mode;
  int         m_t;
  int         m_retry;
  int         m_run;
  logic [2:0] m_lb;

  task automatic model_reset();
    m_mode = MIdle; m_t = 0; m_retry = 0; m_run = 0; m_lb = 3'd0;
  endtask

  task automatic model_restart(input logic [2:0] cfg);
    m_mode = MAttempt; m_t = 0; m_lb = cfg; m_run = 0;
  endtask

  function automatic bit model_qualify(input logic cu);
`ifdef AURORA_SEQ_DEBOUNCE_EN
    return cu && (m_run >= 15);
`else
    return cu;
`endif
  endfunction

  task automatic model_step(input logic en, input logic [2:0] cfg, input logic cu);
    if (!en) begin
      m_mode = MIdle; m_retry = 0; m_run = 0;
      return;
    end
    case (m_mode)
      MIdle: model_restart(cfg);
      MAttempt: begin
        if (m_t < P + R) begin
          m_t++;
        end else if (cfg != m_lb) begin
          model_restart(cfg);
        end else if (model_qualify(cu)) begin
          m_mode = MUp;
        end else if (m_t - (P + R) == T) begin
          m_retry++;
          if (m_retry == MAXR) m_mode = MFail;
          else model_restart(cfg);
        end else begin
          m_run = cu ? m_run + 1 : 0;
          m_t++;
        end
      end
      MUp: begin
        if (cfg != m_lb) begin
          model_restart(cfg);
        end else if (!cu) begin
          m_retry = 0;
          model_restart(cfg);
        end
      end
      default: ;
    endcase
  endtask

  function automatic out_t model_out();
    out_t e;
    e.pma     = (m_mode == MIdle) || (m_mode == MFail) || (m_mode == MAttempt && m_t < P);
    e.rst     = (m_mode != MUp) && !(m_mode == MAttempt && m_t >= P + R);
    e.lb      = m_lb;
    e.start   = (m_mode == MUp);
    e.link_ok = (m_mode == MUp);
    e.fail    = (m_mode == MFail);
    e.retry   = 4'(m_retry);
    return e;
  endfunction

  // Monitor: the DUT presents a full output set every cycle.
  initial begin
    out_t got;
    out_t want;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        checks++;
        got = '{bus.PMA_INIT, bus.RESET, bus.loopback, bus.start, bus.link_ok, bus.fail,
                bus.retry_cnt};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty @%0t: no expected entry for DUT output", $time);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL outputs @%0t: got pma=%b rst=%b lb=%0d start=%b link_ok=%b fail=%b retry=%0d, want pma=%b rst=%b lb=%0d start=%b link_ok=%b fail=%b retry=%0d",
                     $time, got.pma, got.rst, got.lb, got.start, got.link_ok, got.fail,
                     got.retry, want.pma, want.rst, want.lb, want.start, want.link_ok,
                     want.fail, want.retry);
          end
        end
      end
    end
  end

  initial begin
    int   rst_hold;
    int   delay;
    bit   dead;
    bit   noise;
    bit   did_rel_rst;
    logic en_v;
    logic cu_v;
    logic [2:0] cfg_v;

    rst_n_drv = 1'b0;
    en_v = 1'b0; cfg_v = 3'd0; cu_v = 1'b0;
    bus.enable = en_v; bus.loopback_cfg = cfg_v; bus.channel_up = cu_v;
    model_reset();
    rst_hold = 2; delay = 20; dead = 0; noise = 0; did_rel_rst = 0;

    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n_drv = 1'b1;
      end else begin
        model_step(en_v, cfg_v, cu_v);
        if ((!did_rel_rst && i > 1000 && m_mode == MAttempt && m_t == P + 1) ||
            $urandom_range(0, 3999) == 0) begin
          did_rel_rst = 1;
          rst_n_drv = 1'b0;
          model_reset();
          rst_hold = $urandom_range(1, 3);
        end
      end
      exp_q.push_back(model_out());
      mon_on = 1;

      // Next-cycle stimulus; the first bring-up is the nominal loopback-3 case.
      if (i == 5) begin
        en_v = 1'b1; cfg_v = 3'd3; dead = 0; noise = 0; delay = 20;
      end else if (i > 5) begin
        if (en_v) begin
          if ($urandom_range(0, 699) == 0) en_v = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          en_v  = 1'b1;
          dead  = ($urandom_range(0, 4) == 0);
          noise = ($urandom_range(0, 2) == 0);
          case ($urandom_range(0, 5))
            0:       delay = T;
            1:       delay = T + 1;
            2:       delay = T - 1;
            default: delay = $urandom_range(0, 40);
          endcase
        end
        if (i > 60 && $urandom_range(0, 399) == 0) cfg_v = 3'($urandom_range(0, 7));
      end

      case (m_mode)
        MAttempt: begin
          if (m_t >= P + R)
            cu_v = !dead && (m_t - (P + R) >= delay) && !(noise && $urandom_range(0, 24) == 0);
          else
            cu_v = 1'($urandom_range(0, 1));
        end
        MUp:     cu_v = ($urandom_range(0, 99) != 0);
        default: cu_v = 1'($urandom_range(0, 1));
      endcase

      bus.enable = en_v; bus.loopback_cfg = cfg_v; bus.channel_up = cu_v;
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_link_seq.md
# aurora_link_seq

Reset/bring-up sequencer for the Aurora link in `top`. It drives the core's `PMA_INIT` and `RESET` inputs in the required order and applies the requested `loopback` mode at each bring-up. It waits for `channel_up`, retries on timeout, and raises `start` to the traffic logic only once the channel is up. It runs in the `INIT_CLK` domain and replaces the bench-driven reset/PMA_INIT/start stimulus.

## Interface
Parameters:
- `PMA_INIT_CYCLES`, 128: cycles `PMA_INIT` and `RESET` are both held high per attempt (≥2).
- `RESET_HOLD_CYCLES`, 64: cycles `RESET` stays high after `PMA_INIT` falls (≥1).
- `UP_TIMEOUT`, 1048576: cycles to wait for qualified `channel_up` per attempt (≤2^24).
- `MAX_RETRIES`, 4: failed attempts before FAIL (1–15).

Ports:
- `INIT_CLK` in 1: the only clock.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `enable` in 1: level request to bring the link up.
- `loopback_cfg` in 3: requested loopback mode.
- `channel_up` in 1: Aurora channel status (already in the `INIT_CLK` domain).
- `PMA_INIT` out 1: to the Aurora core.
- `RESET` out 1: to the Aurora core (active-high).
- `loopback` out 3: to the Aurora core; latched copy of `loopback_cfg`.
- `start` out 1: traffic enable.
- `link_ok` out 1: the channel is up and qualified.
- `fail` out 1: retries exhausted.
- `retry_cnt` out 4: failed attempts in the current bring-up.

## Operation
- All outputs are registered.
- Reset values: `PMA_INIT`=1, `RESET`=1, `loopback`=0, `start`=0, `link_ok`=0, `fail`=0, `retry_cnt`=0. State after reset is IDLE.
- One cycle counter, 24 bits, cleared on every state entry.
- IDLE
  - Drives `PMA_INIT`=1 and `RESET`=1.
  - Holds `retry_cnt`=0.
  - `enable`=1 → ASSERT.
- ASSERT
  - Latches `loopback_cfg` into `loopback` on entry.
  - Drives `PMA_INIT`=1 and `RESET`=1.
  - After `PMA_INIT_CYCLES` → PMA_REL.
- PMA_REL
  - Drives `PMA_INIT`=0 and `RESET`=1.
  - After `RESET_HOLD_CYCLES` → WAIT_UP.
- WAIT_UP
  - Drives `RESET`=0.
  - Qualified `channel_up` → LINK_UP.
  - When the counter reaches `UP_TIMEOUT`, `retry_cnt` increments.
  - If the new `retry_cnt` equals `MAX_RETRIES` → FAIL; otherwise → ASSERT.
- LINK_UP
  - Drives `link_ok`=1 and `start`=1.
  - `channel_up`=0 for one sampled cycle: `retry_cnt` clears to 0, `link_ok` and `start` drop on the same edge, next state is ASSERT.
- FAIL
  - Drives `fail`=1, `PMA_INIT`=1 and `RESET`=1.
  - Stays until `enable`=0.
- Priority, highest first:
  1. `enable`=0 in any state → IDLE on the next edge. `start`, `link_ok`, `fail` and `retry_cnt` clear; `PMA_INIT`=`RESET`=1.
  2. `loopback_cfg` differs from `loopback` while in WAIT_UP or LINK_UP → ASSERT. `retry_cnt` is unchanged; the new mode is latched on entry.
  3. The state-local transitions above.
- A timeout and a qualified `channel_up` on the same cycle: LINK_UP wins.
- Changes to `loopback_cfg` during ASSERT or PMA_REL are ignored until WAIT_UP.
- `RESET_N` low mid-sequence: all outputs return asynchronously to their reset values.

## Timing
- Edge 0 is the edge that samples `enable`=1 in IDLE and enters ASSERT.
  - `PMA_INIT` falls at edge `PMA_INIT_CYCLES`.
  - `RESET` falls at edge `PMA_INIT_CYCLES`+`RESET_HOLD_CYCLES`.
- `PMA_INIT` never falls while `RESET` is low. `RESET` always falls after `PMA_INIT`.
- Without debounce, `link_ok` and `start` rise 1 edge after `channel_up` is first sampled high in WAIT_UP.
- Timeout retry: the counter reaching `UP_TIMEOUT` causes re-entry to ASSERT on the following edge. `PMA_INIT` and `RESET` rise on that edge.
- An `enable` drop is reflected on the outputs 1 edge later.

## Configuration
- `AURORA_SEQ_DEBOUNCE_EN` defined:
  - `channel_up` is qualified only after 16 consecutive high samples in WAIT_UP, so `link_ok` rises 16 edges after the first high sample.
  - Any low sample restarts the run; the timeout counter is not reset.
- Not defined: qualification is a single high sample, and no debounce logic is present.

## Test plan
- Nominal (`PMA_INIT_CYCLES`=8, `RESET_HOLD_CYCLES`=4, `UP_TIMEOUT`=100): `enable`↑, `loopback_cfg`=3, `channel_up` high 20 cycles after `RESET` falls.
  - Required: `PMA_INIT` low at edge 8, `RESET` low at edge 12, `loopback`=3, `start`=`link_ok`=1 at edge 33.
- Timeout/FAIL (`MAX_RETRIES`=2): `channel_up` held 0.
  - Required: two full PMA/RESET pulses, `retry_cnt` goes 1 then 2, `fail`=1, `PMA_INIT`=`RESET`=1, `start`=0.
  - Then `enable`=0 → IDLE with `fail`=0 and `retry_cnt`=0.
- Link loss: in LINK_UP, drop `channel_up` for 1 cycle.
  - Required: `start` drops on the next edge, a new ASSERT pulse of 8 cycles, `retry_cnt`=0, link returns when `channel_up` is restored.
- Loopback change: in LINK_UP, switch `loopback_cfg` from 3 to 0.
  - Required: restart from ASSERT, `loopback`=0, full PMA_INIT→RESET ordering repeated.
- Async reset: `RESET_N`=0 mid-PMA_REL.
  - Required: immediately `PMA_INIT`=1, `RESET`=1, all status outputs 0; after release the block stays in IDLE until `enable` is seen.
- Debounce build (`AURORA_SEQ_DEBOUNCE_EN`): `channel_up` high 10 cycles, low 1 cycle, then high.
  - Required: `link_ok` rises 16 edges after the re-rise, not before.
